// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample width and stereo frame type.
package audio_pkg;
    localparam int AUDIO_WIDTH = 32;
    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } stereo_sample_t;
endpackage

// File: rtl/stereo_audio_parallelizer_if.sv
// stereo_audio_parallelizer_if: serial tagged-word input and stereo frame output handshakes.
// Ports: i_valid/i_ready/i_is_left/i_audio (serial side), o_valid/o_ready/o_left/o_right (frame side).
// slave = the parallelizer, master = the producer/consumer environment.
interface stereo_audio_parallelizer_if
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
);
    logic             i_valid;
    logic             i_ready;
    logic             i_is_left;
    logic [WIDTH-1:0] i_audio;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_left;
    logic [WIDTH-1:0] o_right;
    modport slave (
        input  i_valid, i_is_left, i_audio, o_ready,
        output i_ready, o_valid, o_left, o_right
    );
    modport master (
        output i_valid, i_is_left, i_audio, o_ready,
        input  i_ready, o_valid, o_left, o_right
    );
endinterface

// File: rtl/stereo_audio_parallelizer_pair_slot.sv
// audio_pair_slot: single-entry valid/ready output register holding one stereo frame.
// Ports: clk, reset, load_i/data_i (new frame), consume_i (downstream ready),
// valid_o/data_o (held frame), ready_o (slot can take a frame this cycle).
module audio_pair_slot
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               consume_i,
    input  logic [2*WIDTH-1:0] data_i,
    output logic               valid_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] data_o
);
    logic               valid_q, valid_d;
    logic [2*WIDTH-1:0] data_q, data_d;
    // A load in the same cycle as a consume replaces the frame and keeps valid high.
    always_comb begin
        valid_d = load_i ? 1'b1 : (consume_i ? 1'b0 : valid_q);
        data_d  = load_i ? data_i : data_q;
    end
    always_ff @(posedge clk) begin
        valid_q <= reset ? 1'b0 : valid_d;
        data_q  <= reset ? '0 : data_d;
    end
    assign ready_o = !valid_q || consume_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/stereo_audio_parallelizer.sv
// stereo_audio_parallelizer: packs alternating left/right serial words into stereo frames.
// Ports: clk, reset (sync, active-high), bus (stereo_audio_parallelizer_if.slave).
// Optional: STEREO_AUDIO_PARALLELIZER_ORDER_CHECK_EN drops right words not preceded by a left.
module stereo_audio_parallelizer
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    stereo_audio_parallelizer_if.slave    bus
);
    logic               in_fire;
    logic               load;
    logic [WIDTH-1:0]   left_q, left_d;
    logic [2*WIDTH-1:0] frame;
    assign in_fire = bus.i_valid && bus.i_ready;
    assign left_d  = (in_fire && bus.i_is_left) ? bus.i_audio : left_q;
`ifdef STEREO_AUDIO_PARALLELIZER_ORDER_CHECK_EN
    logic pend_q, pend_d;
    // A left arms the pair, a right (accepted or dropped) disarms it.
    assign pend_d = in_fire ? bus.i_is_left : pend_q;
    assign load   = in_fire && !bus.i_is_left && pend_q;
    always_ff @(posedge clk) begin
        pend_q <= reset ? 1'b0 : pend_d;
    end
`else
    assign load = in_fire && !bus.i_is_left;
`endif
    always_ff @(posedge clk) begin
        left_q <= reset ? '0 : left_d;
    end
    audio_pair_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load),
        .consume_i (bus.o_ready),
        .data_i    ({left_q, bus.i_audio}),
        .valid_o   (bus.o_valid),
        .ready_o   (bus.i_ready),
        .data_o    (frame)
    );
    assign bus.o_left  = frame[2*WIDTH-1:WIDTH];
    assign bus.o_right = frame[WIDTH-1:0];
endmodule

// File: tb/tb_stereo_audio_parallelizer.sv
// tb_stereo_audio_parallelizer: table-driven pairs with a frame scoreboard plus corner sequences.
module tb_stereo_audio_parallelizer;
    import audio_pkg::*;
    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;
    stereo_audio_parallelizer_if #(.WIDTH(32)) bus ();
    stereo_audio_parallelizer #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    int frames = 0;
    stereo_sample_t exp_q[$];
    logic drop_mode = 0;
    logic ready_base = 1;
    logic fired = 0;
    logic held_v = 0;
    logic [63:0] held = '0;
    stereo_sample_t e;
    vec_t vecs[5];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic send(input logic l, input logic [31:0] d);
        int n = 0;
        bus.i_valid = 1;
        bus.i_is_left = l;
        bus.i_audio = d;
        @(negedge clk);
        while (!bus.i_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.i_ready) begin
            $display("FAIL send_timeout: got i_ready=0 expected 1 within 200 cycles");
            $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
            $fatal(1, "input stalled");
        end
        @(posedge clk);
        #1;
        bus.i_valid = 0;
    endtask
    task automatic push(input logic [31:0] l, input logic [31:0] r);
        stereo_sample_t s;
        s.left = l;
        s.right = r;
        exp_q.push_back(s);
    endtask
    always @(negedge clk) begin
        fired = 0;
        if (!reset) begin
            check("i_ready_rule", {63'd0, bus.i_ready}, {63'd0, !bus.o_valid || bus.o_ready});
            if (held_v && bus.o_valid) check("held_stable", {bus.o_left, bus.o_right}, held);
            if (bus.o_valid && bus.o_ready) begin
                fired = 1;
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %h_%h expected none", bus.o_left, bus.o_right);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", {bus.o_left, bus.o_right}, e);
                end
            end
            held_v = bus.o_valid && !bus.o_ready;
            held = {bus.o_left, bus.o_right};
        end else held_v = 0;
    end
    initial begin
        bus.o_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            bus.o_ready = drop_mode ? !fired : ready_base;
        end
    end
    initial begin
        int f0;
        vecs[0] = '{32'h00010000, 32'h1fed1fed, 32'h00010000, 32'h1fed1fed};
        vecs[1] = '{32'h2eef2eef, 32'h33333333, 32'h2eef2eef, 32'h33333333};
        vecs[2] = '{32'h12345678, 32'h1fed1fed, 32'h12345678, 32'h1fed1fed};
        vecs[3] = '{32'h99911223, 32'hABCDEF01, 32'h99911223, 32'hABCDEF01};
        vecs[4] = '{32'h55555555, 32'h44444444, 32'h55555555, 32'h44444444};
        bus.i_valid = 0;
        bus.i_is_left = 0;
        bus.i_audio = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", {63'd0, bus.o_valid}, 64'd0);
        check("rst_frame", {bus.o_left, bus.o_right}, 64'd0);
        check("rst_i_ready", {63'd0, bus.i_ready}, 64'd1);
        @(posedge clk);
        #1 reset = 0;
        push(32'h00010000, 32'h1fed1fed);
        send(1, 32'h00010000);
        send(0, 32'h1fed1fed);
        @(negedge clk);
        check("latency_o_valid", {63'd0, bus.o_valid}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].el, vecs[i].er);
            send(1, vecs[i].l);
            send(0, vecs[i].r);
        end
        repeat (4) @(negedge clk);
        check("frame_count", frames, 6);
        drop_mode = 1;
        f0 = frames;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].el, vecs[i].er);
            send(1, vecs[i].l);
            send(0, vecs[i].r);
        end
        repeat (6) @(negedge clk);
        check("drop_frame_count", frames - f0, 5);
        drop_mode = 0;
        @(posedge clk);
        #1 ready_base = 0;
        @(posedge clk);
        #1;
        push(32'h01010101, 32'h02020202);
        send(1, 32'h01010101);
        send(0, 32'h02020202);
        bus.i_valid = 1;
        bus.i_is_left = 1;
        bus.i_audio = 32'hAAAA0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_i_ready", {63'd0, bus.i_ready}, 64'd0);
            check("bp_held", {bus.o_left, bus.o_right}, {32'h01010101, 32'h02020202});
        end
        @(posedge clk);
        #1 ready_base = 1;
        push(32'hAAAA0001, 32'hBBBB0002);
        send(1, 32'hAAAA0001);
        send(0, 32'hBBBB0002);
        push(32'h22222222, 32'h33333333);
        send(1, 32'h11111111);
        send(1, 32'h22222222);
        send(0, 32'h33333333);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        send(1, 32'h12121212);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
`ifndef STEREO_AUDIO_PARALLELIZER_ORDER_CHECK_EN
        push(32'h00000000, 32'h0000BEEF);
`endif
        send(0, 32'h0000BEEF);
        @(negedge clk);
`ifdef STEREO_AUDIO_PARALLELIZER_ORDER_CHECK_EN
        check("beef_no_frame", {63'd0, bus.o_valid}, 64'd0);
`else
        check("beef_frame_valid", {63'd0, bus.o_valid}, 64'd1);
`endif
        @(posedge clk);
        #1 ready_base = 0;
        @(posedge clk);
        #1;
        send(1, 32'h0badf00d);
        send(0, 32'h0000cafe);
        reset = 1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_mid_o_valid", {63'd0, bus.o_valid}, 64'd0);
        check("rst_mid_frame", {bus.o_left, bus.o_right}, 64'd0);
        @(posedge clk);
        #1 ready_base = 1;
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stereo_audio_parallelizer.md
# stereo_audio_parallelizer

Converts a serial stream of tagged mono audio words (left/right alternating, one per valid/ready transfer) into parallel stereo frames presented as a left/right pair on a second valid/ready interface. It sits between an I2S/serial audio receiver and frame-oriented processing such as the echo/delay path. One output frame is produced per completed left-then-right input sequence.

## Interface
- `WIDTH`, default 32: bits per audio sample.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `i_valid` input 1: input word present.
- `i_ready` output 1: block accepts input this cycle.
- `i_is_left` input 1: 1 = word is left channel, 0 = right channel.
- `i_audio` input WIDTH: sample word.
- `o_valid` output 1: stereo frame present on `o_left`/`o_right`.
- `o_ready` input 1: downstream accepts frame.
- `o_left` output WIDTH: left sample of frame.
- `o_right` output WIDTH: right sample of frame.

## Operation
- Input transfer occurs when `i_valid && i_ready` at a rising edge; output transfer when `o_valid && o_ready`.
- Left transfer: `i_audio` stored in a left holding register; left-pending flag set. A further left before any right overwrites the held value.
- Right transfer: frame register loads {held left, `i_audio`}; `o_valid` set; left-pending flag cleared.
- `i_ready = !o_valid || o_ready`: input stalls only while an unconsumed frame is held and downstream is not ready. Left and right words are stalled alike.
- `o_valid` stays high, with `o_left`/`o_right` stable, until the frame is consumed.
- Same-cycle output consumption and right transfer: the new frame replaces the old one and `o_valid` stays high.
- Output consumption with no new right word: `o_valid` clears.
- Samples pass bit-exact. No arithmetic is performed and widths are unchanged.

## Timing
- Reset values: `o_valid`=0, `o_left`=0, `o_right`=0, held left=0, left-pending=0. `i_ready` is 1 in and after reset.
- Latency: a right word accepted at edge N gives `o_valid`=1 with the frame during the cycle after edge N (1 cycle).
- Throughput: one frame per two input transfers. No bubbles when `o_ready` is held high.
- Reset asserted mid-frame discards the held left and any pending frame on the next edge.

## Configuration
- `STEREO_AUDIO_PARALLELIZER_ORDER_CHECK_EN` defined:
  - A right word arriving with left-pending=0 is accepted (`i_ready` rule unchanged) and dropped. No frame is produced.
  - Prevents a misaligned start from producing frames with a stale left sample.
- Not defined:
  - The left-pending flag is not used.
  - Every accepted right word produces a frame using whatever the left holding register contains (0 after reset).

## Structure
- Shared package `audio_pkg`: `AUDIO_WIDTH` = 32 constant and a `stereo_sample_t` packed struct {left, right}.
- One natural sub-module, `audio_pair_slot`: a single-entry valid/ready output register with load, consume and ready logic. Its ready output drives `i_ready`.

## Test plan
- Reset, `o_ready`=1: inputs L=00010000, R=1fed1fed -> one frame, o_left=00010000, o_right=1fed1fed, 1 cycle after the right transfer.
- Five back-to-back pairs: (2eef2eef,33333333), (12345678,1fed1fed), (99911223,ABCDEF01), (55555555,44444444), each following the pair above -> frames appear in order with exact values. Frame count = input count / 2.
- Downstream ready pattern: `o_ready` dropped for 1 cycle after each output transfer -> frames held stable and no loss. `i_ready` low only while a frame is held with `o_ready`=0.
- Back-pressure: `o_ready`=0 after a frame, then L=AAAA0001 is offered -> `i_ready`=0 and input stalls. Raising `o_ready` lets it proceed, and the next frame is correct.
- Two lefts (11111111, 22222222) then right 33333333 -> frame {22222222, 33333333}.
- Right 0000BEEF immediately after reset:
  - Macro defined -> no frame.
  - Macro undefined -> frame {00000000, 0000BEEF}.
- Reset asserted after a left only -> next right behaves as after reset.
